// File: rtl/tt_um_pwm_controller_pkg.sv
// Shared constants and types for the four-channel PWM tile.
package tt_um_pwm_controller_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned PSC_W  = 3;
  localparam int unsigned PCNT_W = 7;

  localparam logic [NUM_CH-1:0] EN_RST = 4'hF;

  typedef enum logic [2:0] {
    ADDR_DUTY0 = 3'd0,
    ADDR_DUTY1 = 3'd1,
    ADDR_DUTY2 = 3'd2,
    ADDR_DUTY3 = 3'd3,
    ADDR_PSC   = 3'd4,
    ADDR_EN    = 3'd5,
    ADDR_POL   = 3'd6,
    ADDR_NONE  = 3'd7
  } reg_addr_e;

  // Terminal count of the prescale counter: 2^psc - 1.
  function automatic logic [PCNT_W-1:0] psc_limit(input logic [PSC_W-1:0] psc);
    logic [PCNT_W:0] one;
    one = 8'd1;
    return PCNT_W'((one << psc) - 8'd1);
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty registers, compare and output register.
module pwm_channel
  import tt_um_pwm_controller_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_data,
  input  logic             load,
  input  logic [CNT_W-1:0] cnt,
  input  logic             en,
  input  logic             pol,
  output logic             pwm
);

  logic [CNT_W-1:0] shadow;
  logic [CNT_W-1:0] duty_act;
  logic             raw;
  logic             pwm_q;

  assign raw = (cnt < duty_act);
  assign pwm = pwm_q;

  // A write coinciding with the load leaves the old shadow in duty_act.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow   <= '0;
      duty_act <= '0;
      pwm_q    <= 1'b0;
    end else begin
      if (wr_en) shadow <= wr_data;
      if (load)  duty_act <= shadow;
      pwm_q <= en ? (raw ^ pol) : pol;
    end
  end

endmodule

// File: rtl/tt_um_pwm_controller.sv
// Tiny Tapeout tile: register file, prescaler, shared counter and four PWM channels.
module tt_um_pwm_controller
  import tt_um_pwm_controller_pkg::*;
(
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  reg_addr_e         addr;
  logic              we_q;
  logic              wr;
  logic [PSC_W-1:0]  psc;
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] pol;
  logic [PCNT_W-1:0] pcnt;
  logic [CNT_W-1:0]  cnt;
  logic              tick;
  logic              wrap;
  logic              strobe_q;
  logic [NUM_CH-1:0] pwm;
  logic              unused;

  assign unused  = &{1'b0, ena, uio_in[6:3]};
  assign addr    = reg_addr_e'(uio_in[2:0]);
  assign wr      = uio_in[7] & ~we_q;
  assign tick    = (pcnt == psc_limit(psc));
  assign wrap    = tick & (cnt == '1);

  assign uio_out = '0;
  assign uio_oe  = '0;
  assign uo_out  = {cnt[7:5], strobe_q, pwm};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      psc      <= '0;
      en       <= EN_RST;
      pol      <= '0;
      pcnt     <= '0;
      cnt      <= '0;
      strobe_q <= 1'b0;
    end else begin
      we_q     <= uio_in[7];
      strobe_q <= wrap;
      if (tick) cnt <= cnt + 8'd1;

      // A psc write restarts the prescaler so the new rate starts cleanly.
      if (wr && addr == ADDR_PSC) pcnt <= '0;
      else if (tick)              pcnt <= '0;
      else                        pcnt <= pcnt + 7'd1;

      if (wr) begin
        case (addr)
          ADDR_PSC: psc <= ui_in[PSC_W-1:0];
          ADDR_EN:  en  <= ui_in[NUM_CH-1:0];
          ADDR_POL: pol <= ui_in[NUM_CH-1:0];
          default:  ;
        endcase
      end
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    pwm_channel u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr && (uio_in[2:0] == 3'(ch))),
      .wr_data (ui_in),
      .load    (wrap),
      .cnt     (cnt),
      .en      (en[ch]),
      .pol     (pol[ch]),
      .pwm     (pwm[ch])
    );
  end

endmodule

// File: tb/tb_tt_um_pwm_controller.sv
// Directed bench for tt_um_pwm_controller: per-period high-time and strobe checks.
module tb_tt_um_pwm_controller;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       ena    = 1'b1;
  logic [7:0] ui_in  = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int errors = 0;
  int checks = 0;
  int hi[4];
  int strobes;
  bit last_strobe;

  typedef struct {
    logic [3:0][7:0] duty;
    logic [3:0]      en;
    logic [3:0]      pol;
    logic [2:0]      psc;
    int              period;
    int              h0, h1, h2, h3;
  } vec_t;

  vec_t vecs[8];

  tt_um_pwm_controller dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [7:0] d0, d1, d2, d3, input logic [3:0] en,
                              input logic [3:0] pol, input logic [2:0] psc, input int period,
                              input int h0, h1, h2, h3);
    vec_t v;
    v.duty = {d3, d2, d1, d0};
    v.en = en; v.pol = pol; v.psc = psc; v.period = period;
    v.h0 = h0; v.h1 = h1; v.h2 = h2; v.h3 = h3;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic write_reg(input logic [2:0] addr, input logic [7:0] data);
    @(negedge clk);
    ui_in  = data;
    uio_in = {1'b1, 4'b0, addr};
    @(negedge clk);
    uio_in = {1'b0, 4'b0, addr};
  endtask

  task automatic wait_strobe(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!uo_out[4] && n < 40000);
    checks++;
    if (!uo_out[4]) begin
      errors++;
      $display("FAIL %s: strobe not seen within %0d cycles", name, n);
    end
  endtask

  // Samples p cycles; optionally drives a write held for 'hold' cycles starting at sample wr_at.
  task automatic run_period(input int p, input int wr_at, input logic [7:0] wr_data,
                            input logic [2:0] wr_addr, input int hold);
    for (int c = 0; c < 4; c++) hi[c] = 0;
    strobes = 0;
    last_strobe = 0;
    for (int i = 1; i <= p; i++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) if (uo_out[c]) hi[c]++;
      if (uo_out[4]) strobes++;
      last_strobe = uo_out[4];
      if (i == wr_at) begin
        ui_in  = wr_data;
        uio_in = {1'b1, 4'b0, wr_addr};
      end
      if (i == wr_at + 1) ui_in = ~wr_data;
      if (i == wr_at + hold) uio_in = {1'b0, 4'b0, wr_addr};
    end
  endtask

  initial begin
    int s1, s2, ns, pwm_hi;
    vecs[0] = mk(8'd0,  8'd0,   8'd0,   8'd0, 4'hF,    4'b0000, 3'd0, 256,  0,   0,    0,    0);
    vecs[1] = mk(8'd64, 8'd0,   8'd0,   8'd0, 4'hF,    4'b0000, 3'd0, 256,  64,  0,    0,    0);
    vecs[2] = mk(8'd64, 8'd255, 8'd128, 8'd0, 4'hF,    4'b0100, 3'd0, 256,  64,  255,  128,  0);
    vecs[3] = mk(8'd64, 8'd255, 8'd32,  8'd0, 4'hF,    4'b0100, 3'd0, 256,  64,  255,  224,  0);
    vecs[4] = mk(8'd64, 8'd255, 8'd32,  8'd0, 4'hF,    4'b0100, 3'd3, 2048, 512, 2040, 1792, 0);
    vecs[5] = mk(8'd64, 8'd255, 8'd32,  8'd0, 4'b1110, 4'b0101, 3'd0, 256,  256, 255,  224,  0);
    vecs[6] = mk(8'd0,  8'd255, 8'd32,  8'd1, 4'hF,    4'b1000, 3'd0, 256,  0,   255,  32,   255);
    vecs[7] = mk(8'd64, 8'd0,   8'd0,   8'd0, 4'hF,    4'b0000, 3'd0, 256,  64,  0,    0,    0);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_uo_out", int'(uo_out), 0);
    check("reset_uio_oe", int'(uio_oe), 0);
    check("reset_uio_out", int'(uio_out), 0);
    rst_n = 1'b1;

    // Idle after reset: outputs low, strobe every 256 clocks
    s1 = 0; s2 = 0; ns = 0; pwm_hi = 0;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      if (uo_out[3:0] != 4'h0) pwm_hi++;
      if (uo_out[4]) begin
        ns++;
        if (ns == 1) s1 = i;
        if (ns == 2) s2 = i;
      end
      if (i == 200) check("idle_cnt_msbs", int'(uo_out[7:5]), 6);
    end
    check("idle_pwm_high", pwm_hi, 0);
    check("idle_strobe_count", ns, 2);
    check("idle_first_strobe", s1, 256);
    check("idle_strobe_spacing", s2 - s1, 256);
    check("idle_uio_oe", int'(uio_oe), 0);

    // Table-driven configurations
    for (int v = 0; v < 8; v++) begin
      for (int c = 0; c < 4; c++) write_reg(3'(c), vecs[v].duty[c]);
      write_reg(3'd4, {5'b0, vecs[v].psc});
      write_reg(3'd5, {4'b0, vecs[v].en});
      write_reg(3'd6, {4'b0, vecs[v].pol});
      wait_strobe($sformatf("v%0d_sync", v));
      run_period(vecs[v].period, -1, 8'h00, 3'd7, 0);
      check($sformatf("v%0d_ch0", v), hi[0], vecs[v].h0);
      check($sformatf("v%0d_ch1", v), hi[1], vecs[v].h1);
      check($sformatf("v%0d_ch2", v), hi[2], vecs[v].h2);
      check($sformatf("v%0d_ch3", v), hi[3], vecs[v].h3);
      check($sformatf("v%0d_strobes", v), strobes, 1);
      check($sformatf("v%0d_period_end", v), int'(last_strobe), 1);
    end

    // Mid-period write with strobe held 10 cycles: one write, applied next period
    wait_strobe("hold_sync");
    run_period(256, 30, 8'd200, 3'd0, 10);
    check("hold_cur_period_ch0", hi[0], 64);
    check("hold_cur_period_end", int'(last_strobe), 1);
    run_period(256, -1, 8'h00, 3'd7, 0);
    check("hold_next_period_ch0", hi[0], 200);

    // Write on the wrap edge: new duty lands one period late
    run_period(256, 255, 8'd16, 3'd0, 1);
    check("wrapwr_before_ch0", hi[0], 200);
    run_period(256, -1, 8'h00, 3'd7, 0);
    check("wrapwr_same_edge_ch0", hi[0], 200);
    run_period(256, -1, 8'h00, 3'd7, 0);
    check("wrapwr_later_ch0", hi[0], 16);

    // Asynchronous reset mid-period
    wait_strobe("rst_sync");
    repeat (5) @(negedge clk);
    check("pre_rst_ch0_high", int'(uo_out[0]), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_uo_out", int'(uo_out), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_period(256, -1, 8'h00, 3'd7, 0);
    check("post_rst_ch0", hi[0], 0);
    check("post_rst_ch1", hi[1], 0);
    check("post_rst_strobes", strobes, 1);
    check("post_rst_period_end", int'(last_strobe), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
